// File: rtl/env_player.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// env_player
// Envelope sequencer for the amplitude-modulation stage. Plays a pulse as a run
// of consecutive envelope memory words (NSLICE complex samples per word, one
// word per clock) and drives a gate aligned to the samples. One command is
// buffered behind the running pulse so consecutive pulses play back-to-back.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (accepted when both high)
//   cmd_addr, cmd_len    first word address and length in words (0 = null)
//   memaddr, memen       envelope memory read request
//   memdata              read data, valid RDLAT clocks after the request
//   envxy32x16           samples to the modulator ({envx,envy} per slice)
//   gateout              high while envxy32x16 carries pulse samples
//   busy                 pulse running or reads still in flight
//   pulsecnt             completed pulse counter (ENV_PLAYER_PULSECNT_EN only)
//
// Configuration macro: ENV_PLAYER_PULSECNT_EN adds the pulsecnt output.
// -----------------------------------------------------------------------------
module env_player #(
    parameter int NSLICE = 16,
    parameter int AW     = 12,
    parameter int LW     = 12,
    parameter int RDLAT  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [LW-1:0]        cmd_len,
    output logic [AW-1:0]        memaddr,
    output logic                 memen,
    input  logic [NSLICE*32-1:0] memdata,
    output logic [NSLICE*32-1:0] envxy32x16,
    output logic                 gateout,
    output logic                 busy
`ifdef ENV_PLAYER_PULSECNT_EN
    ,
    output logic [31:0]          pulsecnt
`endif
);

    localparam int DW = NSLICE * 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   addr_cnt_r;
    logic [LW-1:0]   len_cnt_r;
    logic            pend_valid_r;
    logic [AW-1:0]   pend_addr_r;
    logic [LW-1:0]   pend_len_r;
    logic            cmd_ready_r;
    logic            memen_r;
    logic [AW-1:0]   memaddr_r;
    logic [RDLAT-1:0] dly_en_r;
    logic            gate_r;
    logic [DW-1:0]   envxy_r;

    logic            accept_s;
    logic            last_s;
    logic            cand_valid_s;
    logic [AW-1:0]   cand_addr_s;
    logic [LW-1:0]   cand_len_s;
    logic            take_s;

    // Handshake and next-pulse selection; a command arriving on the last word
    // is used directly when nothing is buffered.
    always_comb begin
        accept_s = cmd_valid & cmd_ready_r;
        last_s   = (len_cnt_r == LW'(1'b1));
        if (pend_valid_r) begin
            cand_valid_s = 1'b1;
            cand_addr_s  = pend_addr_r;
            cand_len_s   = pend_len_r;
        end else begin
            cand_valid_s = accept_s;
            cand_addr_s  = cmd_addr;
            cand_len_s   = cmd_len;
        end
        take_s = cand_valid_s & (cand_len_s != {LW{1'b0}});
    end

    // Command FSM: counters, pending slot, read issue and ready flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            addr_cnt_r   <= {AW{1'b0}};
            len_cnt_r    <= {LW{1'b0}};
            pend_valid_r <= 1'b0;
            pend_addr_r  <= {AW{1'b0}};
            pend_len_r   <= {LW{1'b0}};
            cmd_ready_r  <= 1'b0;
            memen_r      <= 1'b0;
            memaddr_r    <= {AW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    memen_r      <= 1'b0;
                    memaddr_r    <= {AW{1'b0}};
                    pend_valid_r <= 1'b0;
                    cmd_ready_r  <= 1'b1;
                    // A null command is consumed here without leaving IDLE.
                    if (accept_s && (cmd_len != {LW{1'b0}})) begin
                        addr_cnt_r <= cmd_addr;
                        len_cnt_r  <= cmd_len;
                        state_r    <= ST_RUN;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    memen_r   <= 1'b1;
                    memaddr_r <= addr_cnt_r;
                    if (last_s) begin
                        pend_valid_r <= 1'b0;
                        cmd_ready_r  <= 1'b1;
                        // Chain straight into the next pulse so memen never drops.
                        if (take_s) begin
                            addr_cnt_r <= cand_addr_s;
                            len_cnt_r  <= cand_len_s;
                            state_r    <= ST_RUN;
                        end else begin
                            state_r    <= ST_IDLE;
                        end
                    end else begin
                        addr_cnt_r <= addr_cnt_r + AW'(1'b1);
                        len_cnt_r  <= len_cnt_r - LW'(1'b1);
                        if (accept_s) begin
                            pend_valid_r <= 1'b1;
                            pend_addr_r  <= cmd_addr;
                            pend_len_r   <= cmd_len;
                            cmd_ready_r  <= 1'b0;
                        end else begin
                            cmd_ready_r  <= ~pend_valid_r;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    memen_r      <= 1'b0;
                    memaddr_r    <= {AW{1'b0}};
                    pend_valid_r <= 1'b0;
                    cmd_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: memen delayed to meet memdata, then both registered out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_en_r <= {RDLAT{1'b0}};
            gate_r   <= 1'b0;
            envxy_r  <= {DW{1'b0}};
        end else begin
            dly_en_r[0] <= memen_r;
            for (int k = 1; k < RDLAT; k++) begin
                dly_en_r[k] <= dly_en_r[k-1];
            end
            gate_r <= dly_en_r[RDLAT-1];
            // Data outside a pulse is never forwarded.
            if (dly_en_r[RDLAT-1]) begin
                envxy_r <= memdata;
            end else begin
                envxy_r <= {DW{1'b0}};
            end
        end
    end

`ifdef ENV_PLAYER_PULSECNT_EN
    logic             memlast_r;
    logic [RDLAT-1:0] dly_last_r;
    logic             out_last_r;
    logic [31:0]      pulsecnt_r;

    // Pulse counter: a last-word tag rides alongside the read pipeline and the
    // count steps as the tagged word leaves the output, i.e. on the gate's
    // falling edge or at a back-to-back boundary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memlast_r  <= 1'b0;
            dly_last_r <= {RDLAT{1'b0}};
            out_last_r <= 1'b0;
            pulsecnt_r <= 32'd0;
        end else begin
            memlast_r     <= (state_r == ST_RUN) & last_s;
            dly_last_r[0] <= memlast_r;
            for (int k = 1; k < RDLAT; k++) begin
                dly_last_r[k] <= dly_last_r[k-1];
            end
            out_last_r <= dly_last_r[RDLAT-1];
            if (gate_r && out_last_r) begin
                pulsecnt_r <= pulsecnt_r + 32'd1;
            end else begin
                pulsecnt_r <= pulsecnt_r;
            end
        end
    end

    assign pulsecnt = pulsecnt_r;
`endif

    assign cmd_ready  = cmd_ready_r;
    assign memen      = memen_r;
    assign memaddr    = memaddr_r;
    assign envxy32x16 = envxy_r;
    assign gateout    = gate_r;
    assign busy       = (state_r == ST_RUN) | memen_r | (|dly_en_r);

endmodule
